ov7670_capture: RTL and testbench

Pixel capture stage directly downstream of the OV7670 camera controller. Once `enable` is high (driven from the controller's `config_finished`), the block locks to the camera's VSYNC/HREF framing and pairs incoming RGB565 bytes into 12-bit RGB444 pixels. It writes each pixel to the frame buffer with a linear raster address and reports frame completion and framing errors. The block runs entirely in the camera pixel-clock domain; the frame buffer's write port lives in that same domain.

---
 rtl/ov7670_capture.sv | 147 ++++++++++++++
 tb/tb_ov7670_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: locks to VSYNC/HREF framing, pairs RGB565 bytes into
// RGB444 pixels and writes them to the frame buffer in linear raster order.
module ov7670_capture #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_VBLANK  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // One extra bit so the pointer can rest at the full-frame count without wrapping.
    localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W+1)'(H_PIXELS * V_LINES);
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // hi_bits carries {hi[7:4], hi[2:0]}, lo_bits carries {lo[7], lo[4:1]}.
    function automatic logic [11:0] rgb565_to_444(input logic [6:0] hi_bits,
                                                  input logic [4:0] lo_bits);
        return {hi_bits[6:3], hi_bits[2:0], lo_bits[4], lo_bits[3:0]};
    endfunction

    logic              vsync_q_r;
    logic              href_q_r;
    logic [7:0]        d_q_r;
    state_t            state_r;
    logic              phase_r;
    logic [6:0]        hi_r;
    logic [ADDR_W:0]   wr_ptr_r;
    logic              err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [11:0]       dout_r;
    logic              we_r;
    logic              frame_done_r;
    logic              frame_err_r;
    logic [7:0]        frame_count_r;

    // Register the camera pins once; every decision below uses these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q_r <= 1'b0;
            href_q_r  <= 1'b0;
            d_q_r     <= 8'h00;
        end else begin
            vsync_q_r <= vsync;
            href_q_r  <= href;
            d_q_r     <= d;
        end
    end

    // Framing state machine, byte pairing, pixel write and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            phase_r       <= 1'b0;
            hi_r          <= 7'h00;
            wr_ptr_r      <= '0;
            err_r         <= 1'b0;
            addr_r        <= '0;
            dout_r        <= 12'h000;
            we_r          <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            we_r         <= 1'b0;
            frame_done_r <= 1'b0;
            if (!enable) begin
                state_r <= ST_IDLE;
                phase_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_WAIT_VS;
                    end
                    ST_WAIT_VS: begin
                        if (vsync_q_r) begin
                            state_r <= ST_VBLANK;
                        end
                    end
                    ST_VBLANK: begin
                        if (!vsync_q_r) begin
                            state_r  <= ST_CAPTURE;
                            wr_ptr_r <= '0;
                            err_r    <= 1'b0;
                            phase_r  <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (vsync_q_r) begin
                            // VSYNC wins over HREF: close the frame, never write.
                            state_r       <= ST_VBLANK;
                            phase_r       <= 1'b0;
                            frame_done_r  <= 1'b1;
                            frame_err_r   <= err_r | (wr_ptr_r != FRAME_PIX);
                            frame_count_r <= frame_count_r + 8'd1;
                        end else if (href_q_r) begin
                            phase_r <= ~phase_r;
                            if (!phase_r) begin
                                hi_r <= {d_q_r[7:4], d_q_r[2:0]};
                            end else if (wr_ptr_r < FRAME_PIX) begin
                                we_r     <= 1'b1;
                                addr_r   <= wr_ptr_r[ADDR_W-1:0];
                                dout_r   <= rgb565_to_444(hi_r, {d_q_r[7], d_q_r[4:1]});
                                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end else begin
                            phase_r <= 1'b0;
                            if (phase_r) begin
                                err_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign addr        = addr_r;
    assign dout        = dout_r;
    assign we          = we_r;
    assign frame_done  = frame_done_r;
    assign frame_err   = frame_err_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: table-driven and random frames compared against a
// byte-stream reference model, plus hand-written abort and start-up sequences.
module tb_ov7670_capture;

    localparam int H_PIX = 4;
    localparam int V_LIN = 2;
    localparam int AW    = 3;
    localparam int NPIX  = H_PIX * V_LIN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          vsync;
    logic          href;
    logic [7:0]    d;
    logic [AW-1:0] addr;
    logic [11:0]   dout;
    logic          we;
    logic          frame_done;
    logic          frame_err;
    logic [7:0]    frame_count;

    ov7670_capture #(.H_PIXELS(H_PIX), .V_LINES(V_LIN), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync), .href(href), .d(d),
        .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int px; } wr_t;
    typedef struct { int err; int cnt; } done_t;
    typedef struct { int nl; int len0; int len1; int len2; bit fixed; int exp_wr; int exp_err; } vec_t;

    wr_t   wr_q[$];
    wr_t   exp_q[$];
    done_t done_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_count = 0;
    int    exp_err;
    logic  we_prev = 1'b0;
    logic [7:0] fb[4][32];
    int    flen[4];
    int    fn;
    vec_t  vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Collect every write and frame_done pulse, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (we === 1'b1) begin
            check("we_spacing", 32'(we_prev), 32'd0);
            wr_q.push_back('{int'(addr), int'(dout)});
        end
        if (frame_done === 1'b1) begin
            done_q.push_back('{int'(frame_err), int'(frame_count)});
        end
        we_prev = we;
    end

    function automatic int pix(input int hi, input int lo);
        int r;
        int g;
        int b;
        r = hi / 16;
        g = (hi % 8) * 2 + lo / 128;
        b = (lo / 2) % 16;
        return r * 256 + g * 16 + b;
    endfunction

    // Reference: each line contributes floor(n/2) pixels; odd lines, overflow and
    // any total other than a full frame flag the frame as bad.
    task automatic model_frame();
        int ptr;
        ptr = 0;
        exp_err = 0;
        exp_q.delete();
        for (int l = 0; l < fn; l++) begin
            for (int i = 0; i + 1 < flen[l]; i += 2) begin
                if (ptr < NPIX) begin
                    exp_q.push_back('{ptr, pix(int'(fb[l][i]), int'(fb[l][i+1]))});
                    ptr++;
                end else begin
                    exp_err = 1;
                end
            end
            if (flen[l] % 2 == 1) exp_err = 1;
        end
        if (ptr != NPIX) exp_err = 1;
    endtask

    task automatic build_frame(input int nl, input int l0, input int l1, input int l2, input bit fixed);
        fn = nl;
        flen[0] = l0;
        flen[1] = l1;
        flen[2] = l2;
        flen[3] = 0;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (fixed) fb[l][i] = (i % 2 == 0) ? 8'hF8 : 8'h1F;
                else       fb[l][i] = 8'($urandom);
            end
        end
    endtask

    task automatic drive_frame();
        for (int l = 0; l < fn; l++) begin
            for (int i = 0; i < flen[l]; i++) begin
                @(negedge clk);
                href = 1'b1;
                d = fb[l][i];
            end
            repeat (2) begin
                @(negedge clk);
                href = 1'b0;
                d = 8'($urandom);
            end
        end
    endtask

    task automatic vblank();
        repeat (4) begin
            @(negedge clk);
            vsync = 1'b1;
            href = 1'b0;
        end
        repeat (2) begin
            @(negedge clk);
            vsync = 1'b0;
        end
    endtask

    task automatic run_frame(input string name, input int exp_wr, input int tbl_err, input bit fixed_chk);
        model_frame();
        wr_q.delete();
        done_q.delete();
        drive_frame();
        vblank();
        exp_count = (exp_count + 1) % 256;
        if (exp_wr >= 0) check({name, "_nwr_table"}, wr_q.size(), exp_wr);
        if (tbl_err >= 0) check({name, "_err_table"}, 32'(frame_err), tbl_err);
        check({name, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check({name, "_addr"}, wr_q[i].a, exp_q[i].a);
            check({name, "_dout"}, wr_q[i].px, exp_q[i].px);
        end
        if (fixed_chk && wr_q.size() > 0) check({name, "_dout_f0f"}, wr_q[0].px, 32'hF0F);
        check({name, "_ndone"}, done_q.size(), 32'd1);
        if (done_q.size() > 0) begin
            check({name, "_err"}, done_q[0].err, exp_err);
            check({name, "_count"}, done_q[0].cnt, exp_count);
        end
    endtask

    initial begin
        vecs[0] = '{2, 8, 8, 0, 1'b1, 8, 0};   // good frame, fixed pattern
        vecs[1] = '{2, 8, 7, 0, 1'b0, 7, 1};   // odd second line
        vecs[2] = '{3, 8, 8, 8, 1'b0, 8, 1};   // overflow
        vecs[3] = '{1, 8, 0, 0, 1'b0, 4, 1};   // short frame
        vecs[4] = '{2, 8, 8, 0, 1'b1, 8, 0};   // good frame after short
        vecs[5] = '{1, 16, 0, 0, 1'b0, 8, 0};  // one long line, exact fill
        vecs[6] = '{2, 9, 9, 0, 1'b0, 8, 1};   // two odd lines
        vecs[7] = '{0, 0, 0, 0, 1'b0, 0, 1};   // empty frame

        rst_n = 1'b0;
        enable = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        d = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        rst_n = 1'b1;

        // Enable while a frame is already streaming: nothing may be written.
        @(negedge clk);
        enable = 1'b1;
        build_frame(1, 8, 0, 0, 1'b0);
        wr_q.delete();
        drive_frame();
        check("midframe_no_we", wr_q.size(), 32'd0);
        done_q.delete();
        vblank();
        check("first_vblank_no_done", done_q.size(), 32'd0);

        for (int v = 0; v < 8; v++) begin
            build_frame(vecs[v].nl, vecs[v].len0, vecs[v].len1, vecs[v].len2, vecs[v].fixed);
            run_frame($sformatf("vec%0d", v), vecs[v].exp_wr, vecs[v].exp_err, vecs[v].fixed);
        end

        for (int r = 0; r < 6; r++) begin
            build_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 1'b0);
            run_frame($sformatf("rnd%0d", r), -1, -1, 1'b0);
        end

        // Drop enable just as the third pixel would be written.
        wr_q.delete();
        done_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            href = 1'b1;
            d = 8'($urandom);
        end
        @(negedge clk);
        enable = 1'b0;
        d = 8'($urandom);
        @(posedge clk);
        #2;
        check("abort_we", 32'(we), 32'd0);
        repeat (2) begin
            @(negedge clk);
            href = 1'b0;
        end
        vblank();
        check("abort_nwr", wr_q.size(), 32'd2);
        check("abort_ndone", done_q.size(), 32'd0);
        check("abort_count", 32'(frame_count), exp_count);

        // Re-enable mid-frame: capture resumes only after a full VBLANK.
        @(negedge clk);
        enable = 1'b1;
        wr_q.delete();
        build_frame(2, 8, 8, 0, 1'b0);
        drive_frame();
        vblank();
        check("reenable_no_we", wr_q.size(), 32'd0);
        check("reenable_no_done", done_q.size(), 32'd0);
        build_frame(2, 8, 8, 0, 1'b1);
        run_frame("after_abort", 8, 0, 1'b1);

        // Reset mid-line.
        @(negedge clk);
        href = 1'b1;
        d = 8'hF8;
        @(negedge clk);
        d = 8'h1F;
        @(negedge clk);
        rst_n = 1'b0;
        href = 1'b0;
        #1;
        check("rst_abort_we", 32'(we), 32'd0);
        check("rst_abort_count", 32'(frame_count), 32'd0);
        @(posedge clk);
        #2;
        check("rst_abort_we_next", 32'(we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
